vram_text_scanner: RTL

- Read side of the 1 KiB VRAM. The CPU writes character codes on port A; this block reads them on port B (v_adb/v_ceb/v_oce/v_dout).
- Generates the 480x272 LCD raster timing.
- Fetches one character code per 8-pixel cell and looks up its glyph row in an external font ROM.
- Drives 16-bit pixels plus DE/HSYNC/VSYNC, all latency-aligned, and a vblank level for the CPU's vsync input.

---
 rtl/vram_text_scanner_if.sv | 20 ++
 rtl/vram_text_scanner.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vram_text_scanner_if.sv
// Port-B VRAM read bus and font ROM lookup bus shared between the text scanner
// (master) and the memories that answer it (slave).
interface vram_text_scanner_if;
  logic [9:0]  v_adb;
  logic        v_ceb;
  logic        v_oce;
  logic [7:0]  v_dout;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output v_adb, v_ceb, v_oce, font_addr,
    input  v_dout, font_data
  );

  modport slave (
    input  v_adb, v_ceb, v_oce, font_addr,
    output v_dout, font_data
  );
endinterface

// File: rtl/vram_text_scanner.sv
// Text-mode LCD scanner: raster counters, per-cell VRAM fetch, font lookup and
// RGB565 pixel output, with DE/HSYNC/VSYNC delayed to line up with the pixels.
module vram_text_scanner #(
  parameter int          H_ACTIVE     = 480,
  parameter int          H_TOTAL      = 525,
  parameter int          H_SYNC_START = 482,
  parameter int          H_SYNC_LEN   = 41,
  parameter int          V_ACTIVE     = 272,
  parameter int          V_TOTAL      = 288,
  parameter int          V_SYNC_START = 274,
  parameter int          V_SYNC_LEN   = 10,
  parameter int          RD_LATENCY   = 2,
  parameter int          FONT_LATENCY = 1,
  parameter logic [15:0] FG_COLOR     = 16'hFFFF,
  parameter logic [15:0] BG_COLOR     = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  vram_text_scanner_if.master mem,
  output logic                lcd_de,
  output logic                lcd_hsync_n,
  output logic                lcd_vsync_n,
  output logic [15:0]         lcd_rgb,
  output logic                vblank
);

  localparam int L    = RD_LATENCY + FONT_LATENCY + 2;
  localparam int HW   = $clog2(H_TOTAL);
  localparam int VW   = $clog2(V_TOTAL);
  localparam int COLS = H_ACTIVE / 8;

  typedef struct packed {
    logic       vld;
    logic       mark;
    logic       hs;
    logic       vs;
    logic [2:0] x;
    logic [3:0] row;
  } stage_t;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [9:0]    v_adb_q, v_adb_d;
  logic          v_ceb_q, v_ceb_d;
  logic          v_oce_q;
  logic [11:0]   font_addr_q, font_addr_d;
  logic [7:0]    glyph_q, glyph_d;
  logic [15:0]   rgb_q, rgb_d;
  logic          vblank_q, vblank_d;
  stage_t        s_p0, f_p1, px_p2;
  stage_t        pipe_q [L];
  stage_t        pipe_d [L];
  logic          pix_bit;

  // Stage 0: raster position, cell fetch request, undelayed sync
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end

    s_p0.vld  = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    s_p0.mark = s_p0.vld && (h_cnt_q[2:0] == 3'd0);
    s_p0.hs   = (int'(h_cnt_q) >= H_SYNC_START) && (int'(h_cnt_q) < H_SYNC_START + H_SYNC_LEN);
    s_p0.vs   = (int'(v_cnt_q) >= V_SYNC_START) && (int'(v_cnt_q) < V_SYNC_START + V_SYNC_LEN);
    s_p0.x    = h_cnt_q[2:0];
    s_p0.row  = v_cnt_q[3:0];

    v_ceb_d  = s_p0.mark;
    v_adb_d  = s_p0.mark ? 10'(((int'(v_cnt_q) >> 4) * COLS) + (int'(h_cnt_q) >> 3)) : v_adb_q;
    vblank_d = int'(v_cnt_d) >= V_ACTIVE;

    pipe_d[0] = s_p0;
    for (int i = 1; i < L; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Stage 1: character code arrives; address the font ROM and hold it for the cell
  always_comb begin
    f_p1        = pipe_q[RD_LATENCY];
    font_addr_d = f_p1.mark ? {mem.v_dout, f_p1.row} : font_addr_q;
  end

  // Stage 2: glyph row arrives; the first pixel of a cell reads it directly
  always_comb begin
    px_p2   = pipe_q[L-2];
    glyph_d = px_p2.mark ? mem.font_data : glyph_q;
    pix_bit = glyph_d[3'd7 - px_p2.x];
    rgb_d   = px_p2.vld ? (pix_bit ? FG_COLOR : BG_COLOR) : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      v_adb_q     <= '0;
      v_ceb_q     <= 1'b0;
      v_oce_q     <= 1'b0;
      font_addr_q <= '0;
      glyph_q     <= '0;
      rgb_q       <= '0;
      vblank_q    <= 1'b0;
      for (int i = 0; i < L; i++) pipe_q[i] <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      v_adb_q     <= v_adb_d;
      v_ceb_q     <= v_ceb_d;
      v_oce_q     <= 1'b1;
      font_addr_q <= font_addr_d;
      glyph_q     <= glyph_d;
      rgb_q       <= rgb_d;
      vblank_q    <= vblank_d;
      pipe_q      <= pipe_d;
    end
  end

  assign mem.v_adb     = v_adb_q;
  assign mem.v_ceb     = v_ceb_q;
  assign mem.v_oce     = v_oce_q;
  assign mem.font_addr = font_addr_d;

  // Sync flags are stored active-high so a flushed pipeline reads as deasserted
  assign lcd_de      = pipe_q[L-1].vld;
  assign lcd_hsync_n = ~pipe_q[L-1].hs;
  assign lcd_vsync_n = ~pipe_q[L-1].vs;
  assign lcd_rgb     = rgb_q;
  assign vblank      = vblank_q;

endmodule
